ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RV32 integer pipeline, directly downstream of the forwarding unit. It applies `forward_a`/`forward_b` selects to the ID/EX operands, computes the ALU result and registers everything into the EX/MEM pipeline register. The registered `rd`/`reg_write` outputs return to the forwarding unit as its EX-hazard inputs. It supports stall (hold) and flush (bubble insertion).

## Interface
- `XLEN`, 32, datapath width
- `clk_i`  input  1  clock, rising edge
- `rst_ni`  input  1  asynchronous reset, active-low
- `valid_i`  input  1  ID/EX holds a real instruction
- `rs1_data_i`, `rs2_data_i`  input  XLEN  register-file operands from ID/EX
- `imm_i`  input  XLEN  sign-extended immediate
- `pc_i`  input  XLEN  instruction PC
- `alu_src_a_pc_i`  input  1  1: operand A = `pc_i`
- `alu_src_b_imm_i`  input  1  1: operand B = `imm_i`
- `alu_op_i`  input  4  ALU operation code, see Operation
- `rd_i`  input  5  destination register
- `reg_write_i`, `mem_read_i`, `mem_write_i`  input  1 each  control bits from ID/EX
- `forward_a_i`, `forward_b_i`  input  2  forwarding selects
- `ex_fwd_data_i`  input  XLEN  EX/MEM result, for select 2'b10
- `mem_fwd_data_i`  input  XLEN  MEM/WB writeback data, for select 2'b01
- `stall_i`  input  1  hold the EX/MEM register
- `flush_i`  input  1  load a bubble into the EX/MEM register
- `mem_valid_o`  output  1  EX/MEM holds a real instruction
- `mem_alu_result_o`  output  XLEN  registered ALU result
- `mem_store_data_o`  output  XLEN  registered forwarded rs2, the store data
- `mem_rd_o`  output  5  registered rd
- `mem_reg_write_o`, `mem_mem_read_o`, `mem_mem_write_o`  output  1 each  registered controls

## Operation
- Forwarded rs1: select 2'b00 gives `rs1_data_i`, 2'b10 gives `ex_fwd_data_i`, 2'b01 gives `mem_fwd_data_i`, 2'b11 gives `rs1_data_i`. Forwarded rs2 uses the same mapping with `rs2_data_i`.
- Operand A is `pc_i` when `alu_src_a_pc_i`, otherwise forwarded rs1.
- Operand B is `imm_i` when `alu_src_b_imm_i`, otherwise forwarded rs2.
- Store data is always forwarded rs2, independent of `alu_src_b_imm_i`.
- ALU ops, all mod 2^XLEN:
  - 0 ADD, 1 SUB.
  - 2 SLL, 6 SRL, 7 SRA. Shift amount is B[4:0] only.
  - 3 SLT (signed), 4 SLTU (unsigned). Result is zero-extended 0/1.
  - 5 XOR, 8 OR, 9 AND.
  - 10 PASS_B (LUI).
  - Codes 11–15 give result 0.
- EX/MEM register update at each rising edge, in priority order:
  1. `flush_i`=1: load a bubble. `mem_valid_o`, `mem_reg_write_o`, `mem_mem_read_o` and `mem_mem_write_o` all go to 0. `mem_rd_o` goes to 0. Data fields may keep their old values.
  2. Else `stall_i`=1: all fields hold.
  3. Else load. `mem_valid_o`=`valid_i`. The controls load as `reg_write_i & valid_i`, `mem_read_i & valid_i` and `mem_write_i & valid_i`. `mem_rd_o` loads `rd_i` when `valid_i`, otherwise 0. Result, store data and rd load from this cycle's values.
- `flush_i` and `stall_i` both high: flush wins.
- Invalid input (`valid_i`=0): no write side-effect may propagate.

## Timing
- All outputs reset to 0 while `rst_ni`=0, asynchronously. Reset mid-instruction discards the in-flight EX/MEM contents.
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- Forwarding muxes and ALU are purely combinational within the cycle. The forwarding data inputs must be stable before the edge.
- During a stall the outputs are constant. The upstream ID/EX register holds the same instruction; this block does not re-sample it.

## Test plan
- Reset: hold `rst_ni`=0 with random inputs -> all outputs 0. Release, then ADD with rs1=5, rs2=7 and `valid_i`=1 -> after 1 edge: result 12, `mem_valid_o`=1.
- Forwarding:
  - `forward_a`=10 with `ex_fwd_data_i`=0x100, `forward_b`=01 with `mem_fwd_data_i`=0x23, SUB -> result 0xDD.
  - `forward_a`=11 -> `rs1_data_i` is used.
- Shift/compare edges:
  - SRA of 0x80000000 by B=0x21 -> 0xC0000000 (amount 1).
  - SLT of 0xFFFFFFFF, 1 -> 1; SLTU of the same -> 0.
  - ADD 0xFFFFFFFF+1 -> 0.
- Store data: `mem_write_i`=1, `alu_src_b_imm_i`=1, imm=8, `forward_b`=10 with `ex_fwd_data_i`=0xABCD -> result = rs1+8, `mem_store_data_o`=0xABCD.
- Stall/flush:
  - `stall_i`=1 for 3 cycles while inputs change -> outputs unchanged.
  - `stall_i`=1 together with `flush_i`=1 -> bubble: valid, reg_write and mem_write all 0, rd 0.
- Invalid input: `valid_i`=0 with `reg_write_i`=1, `mem_write_i`=1, rd=3 -> `mem_reg_write_o`=0, `mem_mem_write_o`=0, `mem_rd_o`=0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the RV32 integer pipeline.
// Applies the forwarding selects to the ID/EX operands, computes the ALU
// result and captures it with the control bits in the EX/MEM register.
// The register supports stall (hold) and flush (bubble insertion); flush wins.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            alu_src_a_pc_i,
    input  logic            alu_src_b_imm_i,
    input  logic [3:0]      alu_op_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [1:0]      forward_a_i,
    input  logic [1:0]      forward_b_i,
    input  logic [XLEN-1:0] ex_fwd_data_i,
    input  logic [XLEN-1:0] mem_fwd_data_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            mem_valid_o,
    output logic [XLEN-1:0] mem_alu_result_o,
    output logic [XLEN-1:0] mem_store_data_o,
    output logic [4:0]      mem_rd_o,
    output logic            mem_reg_write_o,
    output logic            mem_mem_read_o,
    output logic            mem_mem_write_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    // 2'b10 takes the newer EX/MEM value, 2'b01 the MEM/WB value; 2'b11 is
    // not produced by the forwarding unit and falls back to the register file.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_data,
        input logic [XLEN-1:0] ex_data,
        input logic [XLEN-1:0] mem_data
    );
        logic [XLEN-1:0] res;
        case (sel)
            2'b10:   res = ex_data;
            2'b01:   res = mem_data;
            default: res = rf_data;
        endcase
        return res;
    endfunction

    logic [XLEN-1:0] fwd_rs1_s;
    logic [XLEN-1:0] fwd_rs2_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic [4:0]      shamt_s;
    logic [XLEN-1:0] alu_result_s;

    logic            valid_r;
    logic [XLEN-1:0] alu_result_r;
    logic [XLEN-1:0] store_data_r;
    logic [4:0]      rd_r;
    logic            reg_write_r;
    logic            mem_read_r;
    logic            mem_write_r;

    // Operand selection: forwarding first, then PC / immediate override.
    always_comb begin
        fwd_rs1_s = fwd_mux(forward_a_i, rs1_data_i, ex_fwd_data_i, mem_fwd_data_i);
        fwd_rs2_s = fwd_mux(forward_b_i, rs2_data_i, ex_fwd_data_i, mem_fwd_data_i);
        if (alu_src_a_pc_i) begin
            op_a_s = pc_i;
        end else begin
            op_a_s = fwd_rs1_s;
        end
        if (alu_src_b_imm_i) begin
            op_b_s = imm_i;
        end else begin
            op_b_s = fwd_rs2_s;
        end
        shamt_s = op_b_s[4:0];
    end

    // ALU: all arithmetic wraps modulo 2^XLEN; unused opcodes yield zero.
    always_comb begin
        alu_result_s = {XLEN{1'b0}};
        case (alu_op_i)
            OP_ADD:   alu_result_s = op_a_s + op_b_s;
            OP_SUB:   alu_result_s = op_a_s - op_b_s;
            OP_SLL:   alu_result_s = op_a_s << shamt_s;
            OP_SLT:   alu_result_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            OP_SLTU:  alu_result_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            OP_XOR:   alu_result_s = op_a_s ^ op_b_s;
            OP_SRL:   alu_result_s = op_a_s >> shamt_s;
            OP_SRA:   alu_result_s = $unsigned($signed(op_a_s) >>> shamt_s);
            OP_OR:    alu_result_s = op_a_s | op_b_s;
            OP_AND:   alu_result_s = op_a_s & op_b_s;
            OP_PASSB: alu_result_s = op_b_s;
            default:  alu_result_s = {XLEN{1'b0}};
        endcase
    end

    // EX/MEM register: flush inserts a bubble, stall holds, otherwise load.
    // Control bits and rd are gated by valid so a bubble never writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r      <= 1'b0;
            alu_result_r <= {XLEN{1'b0}};
            store_data_r <= {XLEN{1'b0}};
            rd_r         <= 5'd0;
            reg_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
        end else if (flush_i) begin
            valid_r      <= 1'b0;
            alu_result_r <= alu_result_r;
            store_data_r <= store_data_r;
            rd_r         <= 5'd0;
            reg_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
        end else if (stall_i) begin
            valid_r      <= valid_r;
            alu_result_r <= alu_result_r;
            store_data_r <= store_data_r;
            rd_r         <= rd_r;
            reg_write_r  <= reg_write_r;
            mem_read_r   <= mem_read_r;
            mem_write_r  <= mem_write_r;
        end else begin
            valid_r      <= valid_i;
            alu_result_r <= alu_result_s;
            store_data_r <= fwd_rs2_s;
            rd_r         <= valid_i ? rd_i : 5'd0;
            reg_write_r  <= reg_write_i & valid_i;
            mem_read_r   <= mem_read_i & valid_i;
            mem_write_r  <= mem_write_i & valid_i;
        end
    end

    assign mem_valid_o      = valid_r;
    assign mem_alu_result_o = alu_result_r;
    assign mem_store_data_o = store_data_r;
    assign mem_rd_o         = rd_r;
    assign mem_reg_write_o  = reg_write_r;
    assign mem_mem_read_o   = mem_read_r;
    assign mem_mem_write_o  = mem_write_r;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: a constant vector table through a scoreboard queue,
// followed by hand-written reset, stall and flush sequences.
module tb_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i, pc_i;
    logic        alu_src_a_pc_i, alu_src_b_imm_i;
    logic [3:0]  alu_op_i;
    logic [4:0]  rd_i;
    logic        reg_write_i, mem_read_i, mem_write_i;
    logic [1:0]  forward_a_i, forward_b_i;
    logic [31:0] ex_fwd_data_i, mem_fwd_data_i;
    logic        stall_i, flush_i;
    logic        mem_valid_o;
    logic [31:0] mem_alu_result_o, mem_store_data_o;
    logic [4:0]  mem_rd_o;
    logic        mem_reg_write_o, mem_mem_read_o, mem_mem_write_o;

    ex_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
        .alu_src_a_pc_i(alu_src_a_pc_i), .alu_src_b_imm_i(alu_src_b_imm_i),
        .alu_op_i(alu_op_i), .rd_i(rd_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .forward_a_i(forward_a_i), .forward_b_i(forward_b_i),
        .ex_fwd_data_i(ex_fwd_data_i), .mem_fwd_data_i(mem_fwd_data_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .mem_valid_o(mem_valid_o), .mem_alu_result_o(mem_alu_result_o),
        .mem_store_data_o(mem_store_data_o), .mem_rd_o(mem_rd_o),
        .mem_reg_write_o(mem_reg_write_o), .mem_mem_read_o(mem_mem_read_o),
        .mem_mem_write_o(mem_mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] store;
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] rs1, rs2, imm, pc;
        logic        sa, sb;
        logic [1:0]  fa, fb;
        logic [31:0] exf, memf;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        exp_t        e;
    } vec_t;

    int   passed = 0;
    int   total  = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    function automatic vec_t mk(
        input logic valid, input logic [3:0] op,
        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
        input logic sa, input logic sb, input logic [1:0] fa, input logic [1:0] fb,
        input logic [31:0] exf, input logic [31:0] memf,
        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
        input logic [31:0] eres, input logic [31:0] estore, input logic ev,
        input logic [4:0] erd, input logic erw, input logic emr, input logic emw);
        vec_t v;
        v.valid = valid; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
        v.sa = sa; v.sb = sb; v.fa = fa; v.fb = fb; v.exf = exf; v.memf = memf;
        v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw;
        v.e.res = eres; v.e.store = estore; v.e.valid = ev; v.e.rd = erd;
        v.e.rw = erw; v.e.mr = emr; v.e.mw = emw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".result"},    mem_alu_result_o, e.res);
        chk({tag, ".store"},     mem_store_data_o, e.store);
        chk({tag, ".valid"},     {31'd0, mem_valid_o}, {31'd0, e.valid});
        chk({tag, ".rd"},        {27'd0, mem_rd_o}, {27'd0, e.rd});
        chk({tag, ".reg_write"}, {31'd0, mem_reg_write_o}, {31'd0, e.rw});
        chk({tag, ".mem_read"},  {31'd0, mem_mem_read_o}, {31'd0, e.mr});
        chk({tag, ".mem_write"}, {31'd0, mem_mem_write_o}, {31'd0, e.mw});
    endtask

    task automatic drive(input vec_t v);
        valid_i = v.valid; alu_op_i = v.op; rs1_data_i = v.rs1; rs2_data_i = v.rs2;
        imm_i = v.imm; pc_i = v.pc; alu_src_a_pc_i = v.sa; alu_src_b_imm_i = v.sb;
        forward_a_i = v.fa; forward_b_i = v.fb; ex_fwd_data_i = v.exf; mem_fwd_data_i = v.memf;
        rd_i = v.rd; reg_write_i = v.rw; mem_read_i = v.mr; mem_write_i = v.mw;
    endtask

    task automatic drive_random();
        valid_i = 1'($urandom); alu_op_i = 4'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom;
        imm_i = $urandom; pc_i = $urandom; alu_src_a_pc_i = 1'($urandom); alu_src_b_imm_i = 1'($urandom);
        forward_a_i = 2'($urandom); forward_b_i = 2'($urandom); ex_fwd_data_i = $urandom;
        mem_fwd_data_i = $urandom; rd_i = 5'($urandom); reg_write_i = 1'($urandom);
        mem_read_i = 1'($urandom); mem_write_i = 1'($urandom);
    endtask

    // Drive one vector on the falling edge, expect it after the next rising edge.
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk_i);
        drive(v);
        sb_q.push_back(v.e);
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk_outputs(tag, e);
        end
    endtask

    exp_t zero_e;
    exp_t hold_e;
    exp_t bubble_e;

    initial begin
        zero_e = '0;
        stall_i = 1'b0;
        flush_i = 1'b0;

        // Vector table: inputs then expected {res, store, valid, rd, rw, mr, mw}.
        //              valid op     rs1           rs2           imm           pc            sa    sb    fa     fb     exf           memf          rd     rw    mr    mw    eres          estore        ev    erd    erw   emr   emw
        vecs.push_back(mk(1'b1, 4'd0,  32'd5,        32'd7,        32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd1,  1'b1, 1'b0, 1'b0, 32'd12,       32'd7,        1'b1, 5'd1,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd1,  32'h1,        32'h2,        32'd0,        32'd0,        1'b0, 1'b0, 2'b10, 2'b01, 32'h100,      32'h23,       5'd2,  1'b1, 1'b0, 1'b0, 32'hDD,       32'h23,       1'b1, 5'd2,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd0,  32'h50,       32'h10,       32'd0,        32'd0,        1'b0, 1'b0, 2'b11, 2'b00, 32'h999,      32'h777,      5'd3,  1'b1, 1'b0, 1'b0, 32'h60,       32'h10,       1'b1, 5'd3,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd7,  32'h80000000, 32'h21,       32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd4,  1'b1, 1'b0, 1'b0, 32'hC0000000, 32'h21,       1'b1, 5'd4,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd3,  32'hFFFFFFFF, 32'h1,        32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd5,  1'b1, 1'b0, 1'b0, 32'h1,        32'h1,        1'b1, 5'd5,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd4,  32'hFFFFFFFF, 32'h1,        32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd6,  1'b1, 1'b0, 1'b0, 32'h0,        32'h1,        1'b1, 5'd6,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd0,  32'hFFFFFFFF, 32'h1,        32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd7,  1'b1, 1'b0, 1'b0, 32'h0,        32'h1,        1'b1, 5'd7,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd0,  32'h1000,     32'h5555,     32'd8,        32'd0,        1'b0, 1'b1, 2'b00, 2'b10, 32'hABCD,     32'd0,        5'd0,  1'b0, 1'b0, 1'b1, 32'h1008,     32'hABCD,     1'b1, 5'd0,  1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 4'd2,  32'h1,        32'h24,       32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd8,  1'b1, 1'b0, 1'b0, 32'h10,       32'h24,       1'b1, 5'd8,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd6,  32'h80000000, 32'h1F,       32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd9,  1'b1, 1'b0, 1'b0, 32'h1,        32'h1F,       1'b1, 5'd9,  1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd5,  32'hF0F0,     32'h0FF0,     32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd10, 1'b1, 1'b0, 1'b0, 32'hFF00,     32'h0FF0,     1'b1, 5'd10, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd8,  32'hF0F0,     32'h0FF0,     32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd11, 1'b1, 1'b0, 1'b0, 32'hFFF0,     32'h0FF0,     1'b1, 5'd11, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd9,  32'hF0F0,     32'h0FF0,     32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd12, 1'b1, 1'b0, 1'b0, 32'h00F0,     32'h0FF0,     1'b1, 5'd12, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd10, 32'h1234,     32'h99,       32'h12345000, 32'd0,        1'b0, 1'b1, 2'b00, 2'b00, 32'd0,        32'd0,        5'd13, 1'b1, 1'b0, 1'b0, 32'h12345000, 32'h99,       1'b1, 5'd13, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd12, 32'h1234,     32'h99,       32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd14, 1'b1, 1'b0, 1'b0, 32'h0,        32'h99,       1'b1, 5'd14, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 4'd0,  32'h77,       32'h88,       32'd4,        32'h400,      1'b1, 1'b1, 2'b00, 2'b00, 32'd0,        32'd0,        5'd15, 1'b1, 1'b1, 1'b0, 32'h404,      32'h88,       1'b1, 5'd15, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 4'd1,  32'h0,        32'h1,        32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd16, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1,        1'b1, 5'd16, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'd0,  32'h1,        32'h2,        32'd0,        32'd0,        1'b0, 1'b0, 2'b00, 2'b00, 32'd0,        32'd0,        5'd3,  1'b1, 1'b1, 1'b1, 32'h3,        32'h2,        1'b0, 5'd0,  1'b0, 1'b0, 1'b0));

        // Reset with random inputs: everything must read zero.
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            drive_random();
            @(posedge clk_i);
            #1;
        end
        chk_outputs("reset", zero_e);
        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Stall: load a known instruction, then hold for 3 cycles while inputs change.
        step("stall_load", vecs[1]);
        hold_e = vecs[1].e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            drive_random();
            stall_i = 1'b1;
            @(posedge clk_i);
            #1;
            chk_outputs($sformatf("stall%0d", i), hold_e);
        end
        @(negedge clk_i);
        stall_i = 1'b0;

        // Stall and flush together: flush wins, data fields keep their values.
        step("flush_load", vecs[7]);
        bubble_e = vecs[7].e;
        bubble_e.valid = 1'b0; bubble_e.rd = 5'd0;
        bubble_e.rw = 1'b0; bubble_e.mr = 1'b0; bubble_e.mw = 1'b0;
        @(negedge clk_i);
        drive(vecs[0]);
        stall_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("stall_flush.valid",     {31'd0, mem_valid_o}, 32'd0);
        chk("stall_flush.reg_write", {31'd0, mem_reg_write_o}, 32'd0);
        chk("stall_flush.mem_write", {31'd0, mem_mem_write_o}, 32'd0);
        chk("stall_flush.rd",        {27'd0, mem_rd_o}, 32'd0);
        @(negedge clk_i);
        stall_i = 1'b0;
        flush_i = 1'b0;

        // Plain flush after a loading instruction.
        step("flush2_load", vecs[15]);
        bubble_e = vecs[15].e;
        bubble_e.valid = 1'b0; bubble_e.rd = 5'd0;
        bubble_e.rw = 1'b0; bubble_e.mr = 1'b0; bubble_e.mw = 1'b0;
        @(negedge clk_i);
        drive(vecs[0]);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("flush.valid",    {31'd0, mem_valid_o}, 32'd0);
        chk("flush.mem_read", {31'd0, mem_mem_read_o}, 32'd0);
        chk("flush.rd",       {27'd0, mem_rd_o}, 32'd0);
        @(negedge clk_i);
        flush_i = 1'b0;

        // Asynchronous reset mid-instruction clears the register without a clock edge.
        step("async_load", vecs[0]);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_outputs("async_reset", zero_e);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step("after_reset", vecs[3]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
